// File: rtl/div32_seq.sv
// Sequential unsigned restoring divider (one quotient bit per cycle) with a start/done handshake.
// Trial subtraction uses a chain of cla4 slices plus one extra stage for the shifted-out bit.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ {c3, c2, c1, cin};
endmodule

module div32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int unsigned NSL = WIDTH / 4;
  localparam int unsigned CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Partial remainder is kept WIDTH bits wide: its top bit is provably 0 after every
  // iteration, so only the shifted trial value S carries the extra bit.
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] diff;
  logic             carry [0:NSL];
  logic             no_borrow;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;

  assign s        = {r_q, q_q[WIDTH-1]};
  assign nb       = ~dvs_q;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NSL; i++) begin : g_slice
    cla4 u_cla4 (
      .a   (s[4*i +: 4]),
      .b   (nb[4*i +: 4]),
      .cin (carry[i]),
      .sum (diff[4*i +: 4]),
      .cout(carry[i+1])
    );
  end

  // Extra full-adder stage for bit WIDTH: operand bits S[WIDTH] and ~0 = 1.
  assign no_borrow = s[WIDTH] | carry[NSL];
  assign q_step    = {q_q[WIDTH-2:0], no_borrow};
  assign r_step    = no_borrow ? diff : s[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            q_d     = dividend;
            r_d     = '0;
            dvs_d   = divisor;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quotient_d  = q_step;
          remainder_d = r_step;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      q_q         <= '0;
      r_q         <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule
